hack_cpu_ctrl: RTL and testbench

HACK_CPU_CTRL -- requirements
Module: hack_cpu_ctrl

---
 rtl/hack_pkg.sv | 34 +++
 rtl/hack_jump_cond.sv | 26 ++
 rtl/hack_cpu_ctrl.sv | 146 ++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: FSM states, IR field positions, jump codes.
// HACK_HALT_DETECT_EN adds the HALT state used for self-jump detection.
package hack_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEMRD,
    ST_MEMWR
`ifdef HACK_HALT_DETECT_EN
    , ST_HALT
`endif
  } state_t;

  localparam int unsigned IR_CI     = 15;
  localparam int unsigned IR_ABIT   = 12;
  localparam int unsigned IR_CTL_HI = 11;
  localparam int unsigned IR_CTL_LO = 6;
  localparam int unsigned IR_DEST_A = 5;
  localparam int unsigned IR_DEST_D = 4;
  localparam int unsigned IR_DEST_M = 3;
  localparam int unsigned IR_JMP_HI = 2;
  localparam int unsigned IR_JMP_LO = 0;

  localparam logic [2:0] JMP_NULL = 3'b000;
  localparam logic [2:0] JMP_JGT  = 3'b001;
  localparam logic [2:0] JMP_JEQ  = 3'b010;
  localparam logic [2:0] JMP_JGE  = 3'b011;
  localparam logic [2:0] JMP_JLT  = 3'b100;
  localparam logic [2:0] JMP_JNE  = 3'b101;
  localparam logic [2:0] JMP_JLE  = 3'b110;
  localparam logic [2:0] JMP_JMP  = 3'b111;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump decision from the 3-bit jump code and the ALU zero/negative flags.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (jmp)
      JMP_NULL: taken = 1'b0;
      JMP_JGT:  taken = !ng && !zr;
      JMP_JEQ:  taken = zr;
      JMP_JGE:  taken = !ng;
      JMP_JLT:  taken = ng;
      JMP_JNE:  taken = !zr;
      JMP_JLE:  taken = ng || zr;
      JMP_JMP:  taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU controller: fetch/execute FSM with handshaked instruction and data memories, external ALU.
// HACK_HALT_DETECT_EN: a taken jump onto the current PC parks the core in HALT until reset.
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] instr,
  output logic [14:0] dmem_addr,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic        halted
);

  state_t      state, state_nx;
  logic [14:0] pc_q, waddr_q, pc_after_q, pc_target;
  logic [15:0] a_q, d_q, m_q, ir_q, wbuf_q;
  logic        is_c, jmp_raw, taken;

  hack_jump_cond u_jump (
    .jmp   (ir_q[IR_JMP_HI:IR_JMP_LO]),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .taken (jmp_raw)
  );

  assign is_c      = ir_q[IR_CI];
  assign taken     = is_c && jmp_raw;
  // Jump target is A as it stood before this instruction's own A write.
  assign pc_target = taken ? a_q[14:0] : pc_q + 15'd1;

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign alu_x      = d_q;
  assign alu_y      = ir_q[IR_ABIT] ? m_q : a_q;
  assign alu_ctl    = ir_q[IR_CTL_HI:IR_CTL_LO];
  assign dmem_wdata = wbuf_q;

`ifdef HACK_HALT_DETECT_EN
  logic halt_hit, halt_after_q;
  assign halt_hit = taken && (a_q[14:0] == pc_q);
  assign halted   = (state == ST_HALT);
`else
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    imem_req  = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    dmem_addr = a_q[14:0];
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_nx = (instr[IR_CI] && instr[IR_ABIT]) ? ST_MEMRD : ST_EXEC;
      end
      ST_MEMRD: begin
        dmem_re = 1'b1;
        if (dmem_ack) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_c && ir_q[IR_DEST_M]) state_nx = ST_MEMWR;
`ifdef HACK_HALT_DETECT_EN
        else if (halt_hit)           state_nx = ST_HALT;
`endif
        else                         state_nx = ST_FETCH;
      end
      ST_MEMWR: begin
        dmem_we   = 1'b1;
        dmem_addr = waddr_q;
        if (dmem_ack) begin
`ifdef HACK_HALT_DETECT_EN
          state_nx = halt_after_q ? ST_HALT : ST_FETCH;
`else
          state_nx = ST_FETCH;
`endif
        end
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      a_q        <= '0;
      d_q        <= '0;
      m_q        <= '0;
      ir_q       <= '0;
      wbuf_q     <= '0;
      waddr_q    <= '0;
      pc_after_q <= '0;
`ifdef HACK_HALT_DETECT_EN
      halt_after_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: if (imem_ack) ir_q <= instr;
        ST_MEMRD: if (dmem_ack) m_q <= dmem_rdata;
        ST_EXEC: begin
          if (!is_c) begin
            a_q  <= {1'b0, ir_q[14:0]};
            pc_q <= pc_q + 15'd1;
          end else begin
            if (ir_q[IR_DEST_D]) d_q <= alu_out;
            if (ir_q[IR_DEST_A]) a_q <= alu_out;
            // A store defers the PC update until the write handshake completes.
            if (ir_q[IR_DEST_M]) begin
              wbuf_q     <= alu_out;
              waddr_q    <= a_q[14:0];
              pc_after_q <= pc_target;
`ifdef HACK_HALT_DETECT_EN
              halt_after_q <= halt_hit;
`endif
            end else begin
              pc_q <= pc_target;
            end
          end
        end
        ST_MEMWR: if (dmem_ack) pc_q <= pc_after_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: directed scenarios plus random programs against an ISA-level model.
`timescale 1ns/1ps
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [14:0] imem_addr, dmem_addr, pc;
  logic [15:0] instr, dmem_wdata, dmem_rdata, alu_x, alu_y, alu_out;
  logic        dmem_re, dmem_we, dmem_ack, alu_zr, alu_ng, halted;
  logic [5:0]  alu_ctl;

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .instr(instr),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc), .halted(halted)
  );

  int unsigned n_pass = 0, n_total = 0;
  logic [15:0] prog [64];
  logic [15:0] ram_init [64];
  logic [15:0] ram [64];
  logic [15:0] mram [64];
  int unsigned imem_cnt, dmem_cnt, imem_lat, dmem_lat;
  int unsigned ilo = 0, ihi = 0, dlo = 0, dhi = 0;
  bit          prot_en = 1'b0;
  logic [15:0] mA, mD;
  logic [14:0] mpc;
  bit          mhalt;

  function automatic logic [15:0] alu_fn(input logic [15:0] x_in, input logic [15:0] y_in,
                                         input logic [5:0] c);
    logic [15:0] x, y, r;
    x = c[5] ? 16'h0 : x_in;
    if (c[4]) x = ~x;
    y = c[3] ? 16'h0 : y_in;
    if (c[2]) y = ~y;
    r = c[1] ? x + y : x & y;
    if (c[0]) r = ~r;
    return r;
  endfunction

  assign alu_out    = alu_fn(alu_x, alu_y, alu_ctl);
  assign alu_zr     = (alu_out == 16'h0);
  assign alu_ng     = alu_out[15];
  assign instr      = prog[imem_addr[5:0]];
  assign imem_ack   = imem_req && (imem_cnt >= imem_lat);
  assign dmem_rdata = ram[dmem_addr[5:0]];
  assign dmem_ack   = (dmem_re || dmem_we) && (dmem_cnt >= dmem_lat);

  always @(posedge clk) begin
    if (reset) begin
      imem_cnt <= 0;
      dmem_cnt <= 0;
      imem_lat <= $urandom_range(ilo, ihi);
      dmem_lat <= $urandom_range(dlo, dhi);
      for (int i = 0; i < 64; i++) ram[i] <= ram_init[i];
    end else begin
      imem_cnt <= (imem_req && !imem_ack) ? imem_cnt + 1 : 0;
      dmem_cnt <= ((dmem_re || dmem_we) && !dmem_ack) ? dmem_cnt + 1 : 0;
      if (imem_ack) imem_lat <= $urandom_range(ilo, ihi);
      if (dmem_ack) dmem_lat <= $urandom_range(dlo, dhi);
      if (dmem_we && dmem_ack) ram[dmem_addr[5:0]] <= dmem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Memory requests must be exclusive of each other and of fetches.
  always @(negedge clk) begin
    if (prot_en && !reset)
      chk("req_excl", {30'd0, dmem_re & dmem_we, (dmem_re | dmem_we) & imem_req}, 32'd0);
  end

  // ISA-level reference: one whole instruction per call.
  task automatic model_step();
    logic [15:0] ir, y, out, a_old;
    logic lt, eq, gt, tk;
    ir = prog[mpc[5:0]];
    if (!ir[15]) begin
      mA  = {1'b0, ir[14:0]};
      mpc = mpc + 15'd1;
    end else begin
      a_old = mA;
      y   = ir[12] ? mram[a_old[5:0]] : a_old;
      out = alu_fn(mD, y, ir[11:6]);
      if (ir[3]) mram[a_old[5:0]] = out;
      if (ir[4]) mD = out;
      if (ir[5]) mA = out;
      lt = ($signed(out) < 0);
      eq = (out == 16'h0);
      gt = !lt && !eq;
      tk = (ir[2] && lt) || (ir[1] && eq) || (ir[0] && gt);
`ifdef HACK_HALT_DETECT_EN
      if (tk && a_old[14:0] == mpc) mhalt = 1'b1;
`endif
      mpc = tk ? a_old[14:0] : mpc + 15'd1;
    end
  endtask

  task automatic start(input int unsigned il, input int unsigned ih,
                       input int unsigned dl, input int unsigned dh);
    ilo = il; ihi = ih; dlo = dl; dhi = dh;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mA = '0; mD = '0; mpc = '0; mhalt = 1'b0;
    for (int i = 0; i < 64; i++) mram[i] = ram_init[i];
  endtask

  // sel 0: dmem_re high, 1: dmem_we high, 2: start of a new fetch.
  task automatic wait_cond(input int unsigned sel, output bit ok);
    int unsigned t;
    bit seen_low;
    t = 0;
    seen_low = (sel != 2);
    ok = 1'b0;
    while (t < 300 && !ok) begin
      @(negedge clk);
      t++;
      case (sel)
        0: if (dmem_re) ok = 1'b1;
        1: if (dmem_we) ok = 1'b1;
        default: if (!imem_req) seen_low = 1'b1; else if (seen_low) ok = 1'b1;
      endcase
    end
    if (!ok) begin
      n_total++;
      $error("FAIL timeout_sel%0d: observed no event expected one within %0d cycles", sel, t);
    end
  endtask

  task automatic run_checked(input int unsigned n);
    bit ok;
    for (int unsigned i = 0; i <= n; i++) begin
      if (i > 0) begin
        if (mhalt) break;
        wait_cond(2, ok);
        if (!ok) return;
      end
      chk("pc", {17'd0, pc}, {17'd0, mpc});
      chk("a", {17'd0, dmem_addr}, {17'd0, mA[14:0]});
      chk("d", {16'd0, alu_x}, {16'd0, mD});
      if (i < n) model_step();
    end
    if (mhalt) begin
      repeat (4) @(negedge clk);
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin prog[i] = '0; ram_init[i] = '0; end
  endtask

  initial begin
    bit ok;
    int unsigned cnt, bad;
    reset = 1'b1;
    clear_mem();

    // A-instruction, zero-wait: reset state, then A=5, PC=1 two cycles later
    prog[0] = 16'h0005;
    start(0, 0, 0, 0);
    prot_en = 1'b1;
    chk("rst_pc", {17'd0, pc}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_a", {17'd0, dmem_addr}, 32'd0);
    chk("rst_d", {16'd0, alu_x}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("ainst_pc", {17'd0, pc}, 32'd1);
    chk("ainst_a", {17'd0, dmem_addr}, 32'd5);

    // D=A+1 then JGT back to 0
    clear_mem();
    prog[0] = 16'h0007; prog[1] = 16'hEDD0; prog[2] = 16'h0000; prog[3] = 16'hE301;
    start(0, 0, 0, 0);
    run_checked(4);
    chk("jgt_pc", {17'd0, pc}, 32'd0);
    chk("jgt_d", {16'd0, alu_x}, 32'd8);

    // M=D with a three-cycle write stall
    clear_mem();
    prog[0] = 16'h0033; prog[1] = 16'hEC10; prog[2] = 16'h0010; prog[3] = 16'hE308;
    start(0, 0, 3, 3);
    wait_cond(1, ok);
    if (ok) begin
      cnt = 0; bad = 0;
      while (dmem_we && cnt < 20) begin
        if (dmem_addr != 15'h10 || dmem_wdata != 16'h0033) bad++;
        cnt++;
        @(negedge clk);
      end
      chk("wr_cycles", cnt, 32'd4);
      chk("wr_addr_data", bad, 32'd0);
      chk("wr_ram", {16'd0, ram[16]}, 32'h33);
    end

    // AM=M-1 with M=1
    clear_mem();
    ram_init[16] = 16'h0001;
    prog[0] = 16'h0010; prog[1] = 16'hFCA8;
    start(0, 0, 1, 1);
    wait_cond(0, ok);
    if (ok) chk("amm_rd_addr", {17'd0, dmem_addr}, 32'h10);
    wait_cond(1, ok);
    if (ok) begin
      chk("amm_wr_addr", {17'd0, dmem_addr}, 32'h10);
      chk("amm_wr_data", {16'd0, dmem_wdata}, 32'h0);
    end
    wait_cond(2, ok);
    if (ok) chk("amm_a", {17'd0, dmem_addr}, 32'h0);

    // Reset while a read is stalled
    clear_mem();
    prog[0] = 16'h0010; prog[1] = 16'hFC10;
    start(0, 0, 8, 8);
    wait_cond(0, ok);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstrd_re", {31'd0, dmem_re}, 32'd0);
    chk("rstrd_pc", {17'd0, pc}, 32'd0);
    chk("rstrd_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b0;

    // Self-jump at PC 2
    clear_mem();
    prog[0] = 16'h0002; prog[1] = 16'h0002; prog[2] = 16'hEA87;
    start(0, 0, 0, 0);
    run_checked(3);
`ifndef HACK_HALT_DETECT_EN
    run_checked(2);
    chk("selfjmp_halted", {31'd0, halted}, 32'd0);
`endif

    // Random programs with random handshake latency
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) begin
        ram_init[i] = 16'($urandom);
        if ($urandom_range(0, 1) == 0) prog[i] = {1'b0, 15'($urandom)};
        else prog[i] = {1'b1, 2'($urandom), 13'($urandom)};
      end
      start(0, 2, 0, 2);
      run_checked(60);
      bad = 0;
      for (int i = 0; i < 64; i++) if (ram[i] !== mram[i]) bad++;
      chk("rand_ram", bad, 32'd0);
    end

    prot_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
